// File: rtl/multdiv_wb_pkg.sv
// rtl/multdiv_wb_pkg.sv - shared state encoding and constants for the multiply/divide unit
// Contents: state_e (FSM encoding), ITERATIONS (iterations per operation),
// RSTATUS_REG (status register written on exceptions),
// MUL_EXC_CODE / DIV_EXC_CODE (status codes written to RSTATUS_REG).
package multdiv_wb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam int          ITERATIONS   = 32;
    localparam logic [4:0]  RSTATUS_REG  = 5'd30;
    localparam logic [31:0] MUL_EXC_CODE = 32'd4;
    localparam logic [31:0] DIV_EXC_CODE = 32'd5;

endpackage

// File: rtl/multdiv_wb_addsub.sv
// rtl/multdiv_wb_addsub.sv - 32-bit adder/subtractor shared by Booth and restoring datapaths
// Ports:
//   a, b       in  32  operands
//   sub        in  1   1: a - b, 0: a + b
//   signed_op  in  1   1: operands sign-extended, 0: zero-extended
//   sum        out 33  full-precision result; sum[32] is the true sign (signed)
//                      or the borrow (unsigned subtract)
module md_addsub (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        sub,
    input  logic        signed_op,
    output logic [32:0] sum
);

    logic [32:0] a_ext;
    logic [32:0] b_ext;

    always_comb begin
        a_ext = {signed_op & a[31], a};
        b_ext = {signed_op & b[31], b};
        // Two's-complement subtract: invert b and inject the carry-in.
        sum   = a_ext + (b_ext ^ {33{sub}}) + {32'd0, sub};
    end

endmodule

// File: rtl/multdiv_wb.sv
// rtl/multdiv_wb.sv - multi-cycle signed multiply (Booth) / divide (restoring) with register write-back
// Ports:
//   clock, ctrl_reset (async, active-high)
//   ctrl_MULT, ctrl_DIV      start strobes, sampled in IDLE only (MULT has priority)
//   ctrl_destReg             destination register, latched at start
//   data_operandA/B          operands, latched at start
//   busy                     high from start edge through DONE cycle
//   data_resultRDY           one-cycle pulse in DONE
//   data_result              low product word or quotient, held until replaced
//   data_exception           overflow / divide-by-zero, held with data_result
//   ctrl_writeEnable, ctrl_writeReg, data_writeReg   register-file write port
module multdiv_wb
    import multdiv_wb_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [4:0]       ctrl_destReg,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic             busy,
    output logic             data_resultRDY,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             ctrl_writeEnable,
    output logic [4:0]       ctrl_writeReg,
    output logic [WIDTH-1:0] data_writeReg
);

    localparam int PW = 2 * WIDTH + 1;

    state_e           state_q, state_d;
    logic [5:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] opa_q, opa_d;
    logic [WIDTH-1:0] opb_q, opb_d;
    logic [4:0]       dest_q, dest_d;
    logic             is_div_q, is_div_d;
    logic [PW-1:0]    prod_q, prod_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;

    logic [WIDTH-1:0] as_a, as_b;
    logic             as_sub, as_signed;
    logic [WIDTH:0]   as_sum;

    logic [WIDTH-1:0] amag_in, bmag;
    logic [WIDTH-1:0] div_shift, quo;
    logic [WIDTH:0]   booth_hi;

    md_addsub u_addsub (
        .a         (as_a),
        .b         (as_b),
        .sub       (as_sub),
        .signed_op (as_signed),
        .sum       (as_sum)
    );

    // Booth layout: prod[64:33] high word, prod[32:1] low word/multiplier, prod[0] Q-1.
    // Divide layout: prod[63:32] partial remainder, prod[31:0] dividend -> quotient.
    always_comb begin
        amag_in   = data_operandA[WIDTH-1] ? (~data_operandA + 1'b1) : data_operandA;
        bmag      = opb_q[WIDTH-1] ? (~opb_q + 1'b1) : opb_q;
        div_shift = {prod_q[2*WIDTH-2:WIDTH], prod_q[WIDTH-1]};
        quo       = prod_q[WIDTH-1:0];

        if (state_q == DIV) begin
            as_a      = div_shift;
            as_b      = bmag;
            as_sub    = 1'b1;
            as_signed = 1'b0;
        end else begin
            as_a      = prod_q[PW-1:WIDTH+1];
            as_b      = opb_q;
            as_sub    = (prod_q[1:0] == 2'b10);
            as_signed = 1'b1;
        end

        // The 33-bit sum keeps the true sign so the arithmetic shift stays exact
        // even for a most-negative multiplicand.
        if (prod_q[1] != prod_q[0]) begin
            booth_hi = as_sum;
        end else begin
            booth_hi = {prod_q[PW-1], prod_q[PW-1:WIDTH+1]};
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        dest_d   = dest_q;
        is_div_d = is_div_q;
        prod_d   = prod_q;
        result_d = result_q;
        exc_d    = exc_q;

        case (state_q)
            IDLE: begin
                if (ctrl_MULT || ctrl_DIV) begin
                    opa_d    = data_operandA;
                    opb_d    = data_operandB;
                    dest_d   = ctrl_destReg;
                    cnt_d    = '0;
                    is_div_d = !ctrl_MULT;
                    if (ctrl_MULT) begin
                        prod_d  = {{WIDTH{1'b0}}, data_operandA, 1'b0};
                        state_d = MUL;
                    end else begin
                        prod_d  = {{(WIDTH+1){1'b0}}, amag_in};
                        state_d = DIV;
                    end
                end
            end
            MUL: begin
                if (cnt_q == 6'(ITERATIONS)) begin
                    result_d = prod_q[WIDTH:1];
                    exc_d    = prod_q[PW-1:WIDTH+1] != {WIDTH{prod_q[WIDTH]}};
                    state_d  = DONE;
                end else begin
                    prod_d = {booth_hi, prod_q[WIDTH:1]};
                    cnt_d  = cnt_q + 6'd1;
                end
            end
            DIV: begin
                if (opb_q == '0) begin
                    result_d = '0;
                    exc_d    = 1'b1;
                    state_d  = DONE;
                end else if (cnt_q == 6'(ITERATIONS)) begin
                    result_d = (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]) ? (~quo + 1'b1) : quo;
                    // Only -2^31 / -1 overflows; the positive 2^31 wraps to 0x80000000.
                    exc_d    = (opa_q == {1'b1, {(WIDTH-1){1'b0}}}) && (opb_q == '1);
                    state_d  = DONE;
                end else begin
                    // Borrow out means the trial subtract went negative: restore.
                    if (as_sum[WIDTH]) begin
                        prod_d = {1'b0, div_shift, prod_q[WIDTH-2:0], 1'b0};
                    end else begin
                        prod_d = {1'b0, as_sum[WIDTH-1:0], prod_q[WIDTH-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + 6'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            opa_q    <= '0;
            opb_q    <= '0;
            dest_q   <= '0;
            is_div_q <= 1'b0;
            prod_q   <= '0;
            result_q <= '0;
            exc_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            dest_q   <= dest_d;
            is_div_q <= is_div_d;
            prod_q   <= prod_d;
            result_q <= result_d;
            exc_q    <= exc_d;
        end
    end

    always_comb begin
        busy             = (state_q != IDLE);
        data_resultRDY   = (state_q == DONE);
        data_result      = result_q;
        data_exception   = exc_q;
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        if (state_q == DONE) begin
            if (exc_q) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = RSTATUS_REG;
                data_writeReg    = is_div_q ? DIV_EXC_CODE : MUL_EXC_CODE;
            end else if (dest_q != 5'd0) begin
                ctrl_writeEnable = 1'b1;
                ctrl_writeReg    = dest_q;
                data_writeReg    = result_q;
            end
        end
    end

endmodule
